// File: rtl/instr_word_encoder.sv
// MiniMIPS program-load encoder: packs field-level requests into 16-bit words,
// buffers them in a small FIFO and streams them into instruction memory.
module instr_word_encoder #(
    parameter int unsigned ADDR_W     = 8,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_op,
    input  logic [2:0]        in_rs,
    input  logic [2:0]        in_rt,
    input  logic [2:0]        in_rd,
    input  logic [2:0]        in_funct,
    input  logic [5:0]        in_imm,
    input  logic              in_last,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [15:0]       imem_wdata,
    input  logic              imem_wait,
    output logic              busy,
    output logic              done,
    output logic              err_op,
    output logic              err_ovf
);

    localparam int unsigned WORD_W  = 16;
    localparam int unsigned PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W   = PTR_W + 1;
    localparam logic [3:0]  OP_R    = 4'd0;
    localparam logic [3:0]  OP_LAST = 4'd9;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_FLUSH = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;

    logic [WORD_W-1:0]   r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]    r_wr_ptr;
    logic [PTR_W-1:0]    r_rd_ptr;
    logic [CNT_W-1:0]    r_count;
    logic [ADDR_W-1:0]   r_addr;
    logic                r_last_seen;
    logic                r_err_op;
    logic                r_err_ovf;

    logic                w_legal;
    logic [WORD_W-1:0]   w_word;
    logic                w_empty;
    logic                w_full;
    logic                w_active;
    logic                w_start;
    logic                w_accept;
    logic                w_push;
    logic                w_pop;
    logic                w_wr_done;
    logic                w_at_max;

    // Field packing: R-type carries rd/funct, everything else a raw 6-bit immediate
    always_comb begin
        w_legal = (in_op <= OP_LAST);
        w_word  = {in_op, in_rs, in_rt, in_imm};
        if (in_op == OP_R) begin
            w_word = {in_op, in_rs, in_rt, in_rd, in_funct};
        end
    end

    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == CNT_W'(FIFO_DEPTH));
    assign w_active  = (r_state == S_LOAD) || (r_state == S_FLUSH);
    assign w_start   = start && (r_state == S_IDLE);
    assign w_at_max  = (r_addr == {ADDR_W{1'b1}});

    // After overflow the head is discarded every cycle regardless of the memory stall
    assign w_pop     = !w_empty && w_active && (r_err_ovf || !imem_wait);
    assign w_wr_done = w_pop && !r_err_ovf;
    assign w_accept  = in_valid && in_ready;
    assign w_push    = w_accept && w_legal;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_nxt = S_LOAD;
            S_LOAD:  if (w_accept && in_last) w_state_nxt = S_FLUSH;
            S_FLUSH: if (w_empty) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Output logic; in_ready lets a full FIFO take a request on the cycle it pops
    always_comb begin
        in_ready = 1'b0;
        imem_we  = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        case (r_state)
            S_LOAD: begin
                busy     = 1'b1;
                in_ready = !r_last_seen && (!w_full || w_pop);
                imem_we  = !w_empty && !r_err_ovf;
            end
            S_FLUSH: begin
                busy    = 1'b1;
                imem_we = !w_empty && !r_err_ovf;
            end
            S_DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    // Encoded-word FIFO
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= w_word;
                r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Address counter and overflow detection; the counter saturates instead of wrapping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr    <= '0;
            r_err_ovf <= 1'b0;
        end else if (w_start) begin
            r_addr    <= base_addr;
            r_err_ovf <= 1'b0;
        end else if (w_wr_done) begin
            if (w_at_max) begin
                r_err_ovf <= 1'b1;
            end else begin
                r_addr <= r_addr + ADDR_W'(1);
            end
        end
    end

    // Session flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_seen <= 1'b0;
            r_err_op    <= 1'b0;
        end else if (w_start) begin
            r_last_seen <= 1'b0;
            r_err_op    <= 1'b0;
        end else if (w_accept) begin
            if (in_last) begin
                r_last_seen <= 1'b1;
            end
            if (!w_legal) begin
                r_err_op <= 1'b1;
            end
        end
    end

    assign imem_addr  = r_addr;
    assign imem_wdata = r_mem[r_rd_ptr];
    assign err_op     = r_err_op;
    assign err_ovf    = r_err_ovf;

endmodule
